// File: rtl/contador_campos_fecha_pkg.sv
// Shared constants for the date/time field counter.
// Field indices, field limits and a limit lookup helper.
package pkg_reloj;

    localparam int NUM_CAMPOS = 6;

    localparam logic [2:0] CAMPO_SEG  = 3'd0;
    localparam logic [2:0] CAMPO_MIN  = 3'd1;
    localparam logic [2:0] CAMPO_HORA = 3'd2;
    localparam logic [2:0] CAMPO_DIA  = 3'd3;
    localparam logic [2:0] CAMPO_MES  = 3'd4;
    localparam logic [2:0] CAMPO_ANIO = 3'd5;

    localparam logic [6:0] MAX_SEG  = 7'd59;
    localparam logic [6:0] MAX_MIN  = 7'd59;
    localparam logic [6:0] MAX_HORA = 7'd23;
    localparam logic [6:0] MAX_MES  = 7'd11;
    localparam logic [6:0] MAX_ANIO = 7'd99;

    typedef logic [6:0] valor_t;

    // Day limit depends on month/year, so the caller supplies it.
    function automatic valor_t max_campo(
        input logic [2:0] f,
        input logic [4:0] dmax_m1
    );
        valor_t m;
        m = '0;
        unique case (1'b1)
            f == CAMPO_SEG:  m = MAX_SEG;
            f == CAMPO_MIN:  m = MAX_MIN;
            f == CAMPO_HORA: m = MAX_HORA;
            f == CAMPO_DIA:  m = {2'b00, dmax_m1};
            f == CAMPO_MES:  m = MAX_MES;
            f == CAMPO_ANIO: m = MAX_ANIO;
            default:         m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/contador_campos_fecha_if.sv
// Control pulses in, scanned field stream out.
// The master drives buttons/tick, the slave is the counter.
interface contador_campos_fecha_if;

    logic       tick_1hz;
    logic       edit_en;
    logic       btn_up;
    logic       btn_down;
    logic       btn_next;
    logic [3:0] cuenta;
    logic [6:0] cuenta2;
    logic [2:0] campo_edit;

    modport master (
        output tick_1hz,
        output edit_en,
        output btn_up,
        output btn_down,
        output btn_next,
        input  cuenta,
        input  cuenta2,
        input  campo_edit
    );

    modport slave (
        input  tick_1hz,
        input  edit_en,
        input  btn_up,
        input  btn_down,
        input  btn_next,
        output cuenta,
        output cuenta2,
        output campo_edit
    );

endinterface

// File: rtl/contador_campos_fecha_limite_dia_mes.sv
// Last valid 0-based day for a given month index and year.
// Leap years are those with year divisible by 4 (2000..2099).
module limite_dia_mes
    import pkg_reloj::*;
(
    input  logic [3:0] month,
    input  logic [6:0] year,
    output logic [4:0] dmax_m1
);

    logic bisiesto;

    assign bisiesto = ((year & 7'h03) == 7'h00);

    always_comb begin
        dmax_m1 = 5'd30;
        unique case (1'b1)
            month == 4'd1:  dmax_m1 = bisiesto ? 5'd28 : 5'd27;
            month == 4'd3,
            month == 4'd5,
            month == 4'd8,
            month == 4'd10: dmax_m1 = 5'd29;
            default:        dmax_m1 = 5'd30;
        endcase
    end

endmodule

// File: rtl/contador_campos_fecha.sv
// Date/time field registers with carry, edit and a round-robin
// scan that feeds the downstream binary-to-BCD display decoder.
module contador_campos_fecha
    import pkg_reloj::*;
(
    input  logic clk,
    input  logic reset_n,
    contador_campos_fecha_if.slave bus
);

    valor_t     campo_q   [NUM_CAMPOS];
    valor_t     campo_pre [NUM_CAMPOS];
    valor_t     campo_d   [NUM_CAMPOS];
    logic [2:0] cursor_q;
    logic [2:0] cursor_d;
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic [3:0] cuenta_q;
    valor_t     cuenta2_q;
    logic [4:0] dmax_act;
    logic [4:0] dmax_nxt;
    logic       acarreo;
    valor_t     lim;
    valor_t     valor;
    logic       sube;
    logic       baja;

    limite_dia_mes u_lim_act (
        .month   (campo_q[CAMPO_MES][3:0]),
        .year    (campo_q[CAMPO_ANIO]),
        .dmax_m1 (dmax_act)
    );

    limite_dia_mes u_lim_nxt (
        .month   (campo_pre[CAMPO_MES][3:0]),
        .year    (campo_pre[CAMPO_ANIO]),
        .dmax_m1 (dmax_nxt)
    );

    assign sube = bus.btn_up & ~bus.btn_down;
    assign baja = bus.btn_down & ~bus.btn_up;

    always_comb begin
        campo_pre = campo_q;
        cursor_d  = cursor_q;
        acarreo   = 1'b0;
        lim       = '0;
        valor     = '0;
        if (!bus.edit_en) begin
            if (bus.tick_1hz) begin
                acarreo = 1'b1;
                for (int i = 0; i < NUM_CAMPOS; i++) begin
                    lim = max_campo(3'(i), dmax_act);
                    if (acarreo) begin
                        if (campo_q[i] == lim) begin
                            campo_pre[i] = '0;
                        end else begin
                            campo_pre[i] = campo_q[i] + 7'd1;
                            acarreo      = 1'b0;
                        end
                    end
                end
            end
        end else begin
            lim   = max_campo(cursor_q, dmax_act);
            valor = campo_q[cursor_q];
            if (sube) begin
                campo_pre[cursor_q] = (valor == lim) ? '0 : valor + 7'd1;
            end else if (baja) begin
                campo_pre[cursor_q] = (valor == '0) ? lim : valor - 7'd1;
            end
            if (bus.btn_next) begin
                cursor_d = (cursor_q == CAMPO_ANIO) ? CAMPO_SEG
                                                    : cursor_q + 3'd1;
            end
        end
    end

    // Clamp against the month/year being written, not the old ones.
    always_comb begin
        campo_d = campo_pre;
        if (campo_pre[CAMPO_DIA] > {2'b00, dmax_nxt}) begin
            campo_d[CAMPO_DIA] = {2'b00, dmax_nxt};
        end
    end

    assign ptr_d = (ptr_q == 3'(NUM_CAMPOS - 1)) ? '0 : ptr_q + 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CAMPOS; i++) begin
                campo_q[i] <= '0;
            end
            cursor_q  <= '0;
            ptr_q     <= '0;
            cuenta_q  <= '0;
            cuenta2_q <= '0;
        end else begin
            campo_q   <= campo_d;
            cursor_q  <= cursor_d;
            ptr_q     <= ptr_d;
            cuenta_q  <= {1'b0, ptr_q};
            cuenta2_q <= campo_q[ptr_q];
        end
    end

    assign bus.cuenta     = cuenta_q;
    assign bus.cuenta2    = cuenta2_q;
    assign bus.campo_edit = cursor_q;

endmodule
